// File: rtl/act_frame_if.sv
// act_frame_if: stream bundle between the layer-4 activation producer, the
// frame collector and the layer-5 neuron node.
//
// Parameters:
//   N_IN - words per frame (neuron fan-in)
//   DW   - word width
//
// Signals:
//   in_valid / in_ready / in_sof / in_data  serial word stream, one word per beat
//   out_valid / out_ready / out_acts        parallel frame handoff to the consumer
//
// Modports:
//   slave  - the collector (accepts the serial stream, presents the frame)
//   master - the environment (producer plus consumer)
interface act_frame_if #(
  parameter int N_IN = 30,
  parameter int DW   = 32
);
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_sof;
  logic [DW-1:0]        in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [N_IN*DW-1:0]   out_acts;

  modport slave (
    input  in_valid, in_sof, in_data, out_ready,
    output in_ready, out_valid, out_acts
  );

  modport master (
    output in_valid, in_sof, in_data, out_ready,
    input  in_ready, out_valid, out_acts
  );
endinterface

// File: rtl/act_frame_collector.sv
// act_frame_collector: assembles N_IN serial activation words into one
// parallel frame for a combinational neuron node and holds the frame stable
// until the consumer takes it.
//
// Ports:
//   clk      - rising-edge clock
//   rst_n    - asynchronous active-low reset
//   bus      - act_frame_if.slave (serial input stream, parallel frame output;
//              slot k of out_acts sits at bits [DW*k +: DW])
//   fill_idx - next slot to be written (debug)
//   err_sync - one-cycle pulse when an in_sof beat discards a partial frame
//
// Optional build macro:
//   ACT_FLUSH_NONFINITE_EN - when defined, Inf/NaN words and denormals are
//   captured as 32'h0000_0000; otherwise words are stored bit-exact.
module act_frame_collector #(
  parameter int N_IN  = 30,
  parameter int DW    = 32,
  parameter int IDX_W = $clog2(N_IN)
) (
  input  logic             clk,
  input  logic             rst_n,
  act_frame_if.slave       bus,
  output logic [IDX_W-1:0] fill_idx,
  output logic             err_sync
);

  localparam logic [0:0]       FILL     = 1'b0;
  localparam logic [0:0]       FULL     = 1'b1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_IN - 1);

  logic [0:0]       state_reg;
  logic [0:0]       state_next;
  logic [IDX_W-1:0] fill_idx_reg;
  logic [IDX_W-1:0] fill_idx_next;
  logic             in_ready_reg;
  logic             err_sync_reg;

  logic             beat;
  logic             resync;
  logic [IDX_W-1:0] wr_idx;
  logic [DW-1:0]    cap_data;

  // in_ready_reg is only ever high in FILL, so it alone qualifies a beat.
  assign beat   = bus.in_valid & in_ready_reg;
  // A start-of-frame marker anywhere but slot 0 restarts the frame.
  assign resync = beat & bus.in_sof & (fill_idx_reg != '0);
  assign wr_idx = resync ? '0 : fill_idx_reg;

  always_comb begin
    state_next    = state_reg;
    fill_idx_next = fill_idx_reg;
    case (state_reg)
      FILL: begin
        if (beat) begin
          if (resync) begin
            fill_idx_next = IDX_W'(1);
          end else if (fill_idx_reg == LAST_IDX) begin
            fill_idx_next = '0;
            state_next    = FULL;
          end else begin
            fill_idx_next = fill_idx_reg + 1'b1;
          end
        end
      end
      FULL: begin
        if (bus.out_ready) begin
          state_next = FILL;
        end
      end
      default: begin
        state_next    = FILL;
        fill_idx_next = '0;
      end
    endcase
  end

  // in_ready is registered from the next state, so it stays low while reset
  // is held, rises on the first clock after release, and has no
  // combinational path from out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= FILL;
      fill_idx_reg <= '0;
      in_ready_reg <= 1'b0;
      err_sync_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      fill_idx_reg <= fill_idx_next;
      in_ready_reg <= (state_next == FILL);
      err_sync_reg <= resync;
    end
  end

`ifdef ACT_FLUSH_NONFINITE_EN
  // Specials and denormals would upset the downstream multiplier/adder
  // chain, so they are replaced by +0 on capture.
  logic [7:0] cap_exp;
  logic       cap_mant_nz;

  assign cap_exp     = bus.in_data[30:23];
  assign cap_mant_nz = |bus.in_data[22:0];

  always_comb begin
    cap_data = bus.in_data;
    if (cap_exp == 8'hFF) begin
      cap_data = '0;
    end else if ((cap_exp == 8'h00) && cap_mant_nz) begin
      cap_data = '0;
    end
  end
`else
  assign cap_data = bus.in_data;
`endif

  // One register per slot; slots not rewritten in a new frame keep their
  // previous contents, which is harmless because out_valid is low then.
  for (genvar gi = 0; gi < N_IN; gi++) begin : g_slot
    logic [DW-1:0] slot_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        slot_reg <= '0;
      end else if (beat && (wr_idx == IDX_W'(gi))) begin
        slot_reg <= cap_data;
      end
    end

    assign bus.out_acts[DW*gi +: DW] = slot_reg;
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = (state_reg == FULL);
  assign fill_idx      = fill_idx_reg;
  assign err_sync      = err_sync_reg;

endmodule

// File: tb/tb_act_frame_collector.sv
// tb_act_frame_collector: directed self-checking bench for act_frame_collector.
// Inputs are driven 1 ns after the rising edge; outputs are sampled there too.
module tb_act_frame_collector;
  localparam int N  = 30;
  localparam int DW = 32;
  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] fill_idx;
  logic       err_sync;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_frame [N];

  act_frame_if #(.N_IN(N), .DW(DW)) bus ();

  act_frame_collector #(.N_IN(N), .DW(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .fill_idx (fill_idx),
    .err_sync (err_sync)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] slot(input int k);
    return bus.out_acts[k*DW +: DW];
  endfunction

  // Presents one word and holds it until it is handshaked (bounded wait).
  task automatic send_beat(input logic [31:0] d, input logic sof);
    int n;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_sof   = sof;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout: in_ready=%b required 1", bus.in_ready);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    bus.in_data  = JUNK;
  endtask

  task automatic accept_frame();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b required 0", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b required 0", bus.out_valid); end
    checks++; if (fill_idx !== 5'd0) begin errors++; $display("FAIL rst_fill_idx: got %0d required 0", fill_idx); end
    checks++; if (err_sync !== 1'b0) begin errors++; $display("FAIL rst_err_sync: got %b required 0", err_sync); end
    checks++; if (bus.out_acts !== '0) begin errors++; $display("FAIL rst_out_acts: got nonzero required 0"); end
    rst_n = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_release_ready: got %b required 0 before clock", bus.in_ready); end
    @(posedge clk); #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_first_clock_ready: got %b required 1", bus.in_ready); end
    $display("test_reset done");
  endtask

  task automatic test_fill();
    int early;
    int bad;
    early = 0;
    for (int k = 0; k < N; k++) begin
      exp_frame[k] = 32'h3F80_0000 + k;
      send_beat(exp_frame[k], k == 0);
      if (k < N - 1 && bus.out_valid !== 1'b0) early++;
    end
    checks++; if (early != 0) begin errors++; $display("FAIL fill_early_valid: got %0d early cycles required 0", early); end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL fill_out_valid: got %b required 1", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready: got %b required 0", bus.in_ready); end
    checks++; if (fill_idx !== 5'd0) begin errors++; $display("FAIL fill_idx_wrap: got %0d required 0", fill_idx); end
    bad = 0;
    for (int k = 0; k < N; k++) begin
      if (slot(k) !== exp_frame[k]) begin
        bad++;
        $display("FAIL fill_slot%0d: got %h required %h", k, slot(k), exp_frame[k]);
      end
    end
    checks++; if (bad != 0) errors++;
    // Hold with junk offered on the input; the frame must not move.
    bad = 0;
    bus.in_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      bus.in_data = JUNK + c;
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b1) bad++;
      for (int k = 0; k < N; k++) if (slot(k) !== exp_frame[k]) bad++;
    end
    bus.in_valid = 1'b0;
    bus.in_data  = JUNK;
    checks++; if (bad != 0) begin errors++; $display("FAIL fill_hold_stable: got %0d deviations required 0", bad); end
    $display("test_fill done");
  endtask

  task automatic test_throughput();
    int cyc;
    int k;
    int bad;
    logic rdy;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL tp_valid_drop: got %b required 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL tp_ready_rise: got %b required 1", bus.in_ready); end
    checks++; if (fill_idx !== 5'd0) begin errors++; $display("FAIL tp_fill_idx: got %0d required 0", fill_idx); end
    cyc = 1;
    k = 0;
    bus.in_valid = 1'b1;
    while (!bus.out_valid && cyc < 60) begin
      bus.in_data = 32'h4040_0000 + k;
      bus.in_sof  = (k == 0);
      rdy = bus.in_ready;
      @(posedge clk); #1;
      if (rdy) k++;
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    checks++; if (cyc != 31) begin errors++; $display("FAIL tp_period: got %0d cycles required 31", cyc); end
    checks++; if (k != N) begin errors++; $display("FAIL tp_beats: got %0d beats required %0d", k, N); end
    bad = 0;
    for (int j = 0; j < N; j++) if (slot(j) !== 32'h4040_0000 + j) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL tp_frame: got %0d wrong slots required 0", bad); end
    accept_frame();
    $display("test_throughput done");
  endtask

  task automatic test_resync();
    int bad;
    for (int k = 0; k < 12; k++) send_beat(32'h4100_0000 + k, k == 0);
    checks++; if (err_sync !== 1'b0) begin errors++; $display("FAIL rs_no_early_err: got %b required 0", err_sync); end
    send_beat(32'h4000_0000, 1'b1);
    checks++; if (err_sync !== 1'b1) begin errors++; $display("FAIL rs_err_pulse: got %b required 1", err_sync); end
    checks++; if (fill_idx !== 5'd1) begin errors++; $display("FAIL rs_fill_idx: got %0d required 1", fill_idx); end
    checks++; if (slot(0) !== 32'h4000_0000) begin errors++; $display("FAIL rs_slot0: got %h required 40000000", slot(0)); end
    for (int k = 1; k < N; k++) begin
      send_beat(32'h4000_0000 + k, 1'b0);
      if (k == 1) begin
        checks++; if (err_sync !== 1'b0) begin errors++; $display("FAIL rs_err_one_cycle: got %b required 0", err_sync); end
      end
    end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL rs_complete: got %b required 1", bus.out_valid); end
    bad = 0;
    for (int k = 0; k < N; k++) if (slot(k) !== 32'h4000_0000 + k) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL rs_frame: got %0d wrong slots required 0", bad); end
    accept_frame();
    $display("test_resync done");
  endtask

  task automatic test_sof_last();
    int bad;
    for (int k = 0; k < N - 1; k++) send_beat(32'h4200_0000 + k, k == 0);
    send_beat(32'h4300_0000, 1'b1);
    checks++; if (err_sync !== 1'b1) begin errors++; $display("FAIL sl_err_pulse: got %b required 1", err_sync); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL sl_no_complete: got %b required 0", bus.out_valid); end
    checks++; if (fill_idx !== 5'd1) begin errors++; $display("FAIL sl_fill_idx: got %0d required 1", fill_idx); end
    for (int k = 1; k < N; k++) send_beat(32'h4300_0000 + k, 1'b0);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL sl_complete: got %b required 1", bus.out_valid); end
    bad = 0;
    for (int k = 0; k < N; k++) if (slot(k) !== 32'h4300_0000 + k) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL sl_frame: got %0d wrong slots required 0", bad); end
    accept_frame();
    $display("test_sof_last done");
  endtask

  task automatic test_gaps();
    int gap;
    int early;
    int bad;
    early = 0;
    for (int k = 0; k < N; k++) begin
      gap = $urandom_range(0, 5);
      bus.in_valid = 1'b0;
      bus.in_data  = JUNK;
      repeat (gap) begin
        @(posedge clk); #1;
        if (bus.out_valid !== 1'b0) early++;
      end
      send_beat(32'hC000_0000 + k, k == 0);
      if (k < N - 1 && bus.out_valid !== 1'b0) early++;
    end
    checks++; if (early != 0) begin errors++; $display("FAIL gap_early_valid: got %0d early cycles required 0", early); end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL gap_complete: got %b required 1", bus.out_valid); end
    bad = 0;
    for (int k = 0; k < N; k++) if (slot(k) !== 32'hC000_0000 + k) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL gap_frame: got %0d wrong slots required 0", bad); end
    accept_frame();
    $display("test_gaps done");
  endtask

  task automatic test_async_reset();
    int bad;
    for (int k = 0; k < 17; k++) send_beat(32'h3E00_0000 + k, k == 0);
    checks++; if (fill_idx !== 5'd17) begin errors++; $display("FAIL ar_pre_idx: got %0d required 17", fill_idx); end
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (fill_idx !== 5'd0) begin errors++; $display("FAIL ar_fill_idx: got %0d required 0", fill_idx); end
    checks++; if (bus.out_acts !== '0) begin errors++; $display("FAIL ar_out_acts: got nonzero required 0"); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL ar_out_valid: got %b required 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL ar_in_ready: got %b required 0", bus.in_ready); end
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL ar_ready_after: got %b required 1", bus.in_ready); end
    send_beat(32'h3D00_0000, 1'b0);
    checks++; if (slot(0) !== 32'h3D00_0000 || fill_idx !== 5'd1 || err_sync !== 1'b0) begin
      errors++;
      $display("FAIL ar_first_word: got slot0=%h idx=%0d err=%b required 3d000000 1 0", slot(0), fill_idx, err_sync);
    end
    for (int k = 1; k < N; k++) send_beat(32'h3D00_0000 + k, 1'b0);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL ar_complete: got %b required 1", bus.out_valid); end
    bad = 0;
    for (int k = 0; k < N; k++) if (slot(k) !== 32'h3D00_0000 + k) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL ar_frame: got %0d wrong slots required 0", bad); end
    accept_frame();
    $display("test_async_reset done");
  endtask

  task automatic test_flush();
    logic [31:0] sent [N];
    logic [31:0] want [N];
    int bad;
    for (int k = 0; k < N; k++) sent[k] = 32'h3F80_0000;
    sent[3] = 32'h7FC0_0000;
    sent[4] = 32'hFF80_0000;
    sent[5] = 32'h8000_0001;
    sent[6] = 32'hBF80_0000;
    for (int k = 0; k < N; k++) want[k] = sent[k];
`ifdef ACT_FLUSH_NONFINITE_EN
    want[3] = 32'h0000_0000;
    want[4] = 32'h0000_0000;
    want[5] = 32'h0000_0000;
`endif
    for (int k = 0; k < N; k++) send_beat(sent[k], k == 0);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL fl_complete: got %b required 1", bus.out_valid); end
    for (int k = 3; k <= 6; k++) begin
      checks++;
      if (slot(k) !== want[k]) begin
        errors++;
        $display("FAIL fl_slot%0d: got %h required %h", k, slot(k), want[k]);
      end
    end
    bad = 0;
    for (int k = 0; k < N; k++) if (slot(k) !== want[k]) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL fl_frame: got %0d wrong slots required 0", bad); end
    accept_frame();
    $display("test_flush done");
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_sof    = 1'b0;
    bus.in_data   = JUNK;
    bus.out_ready = 1'b0;
    test_reset();
    test_fill();
    test_throughput();
    test_resync();
    test_sof_last();
    test_gaps();
    test_async_reset();
    test_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
